// File: rtl/ram_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_writer_pkg
//  Description : Shared definitions for the burst RAM writer: FSM state
//                encoding, default geometry and the storage byte width.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_writer_pkg;

  localparam int c_depth  = 256;  // default number of byte locations
  localparam int c_aw     = 8;    // default address width (c_depth = 2**c_aw)
  localparam int c_byte_w = 8;    // width of one storage location

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : ram_writer_pkg
`default_nettype wire

// File: rtl/ram_writer_ram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ram_bank
//  Description : DEPTH x 8-bit flop-based storage with one synchronous write
//                port and one zero-latency combinational read port.
//                Reset clears every location asynchronously.
//  Ports       : clk    - clock
//                rst    - asynchronous active-high reset (clears storage)
//                we     - write enable, stores wdata at waddr on rising edge
//                waddr  - write address
//                wdata  - write byte
//                raddr  - read address
//                rdata  - byte currently held at raddr
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_bank
  import ram_writer_pkg::*;
#(
  parameter int DEPTH = c_depth,
  parameter int AW    = c_aw
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [c_byte_w-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [c_byte_w-1:0] rdata
);

  logic [c_byte_w-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // A same-cycle write to raddr is only visible after the edge, so the read
  // port naturally returns the old byte during the write cycle.
  assign rdata = r_mem[raddr];

endmodule : ram_bank
`default_nettype wire

// File: rtl/ram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : ram_writer
//  Description : Burst writer into a DEPTH-byte local RAM. A start request in
//                IDLE latches a start address and a byte count; bytes offered
//                on the wr_valid/wr_ready handshake are written to consecutive
//                addresses (wrapping at DEPTH), then a one-cycle done pulse is
//                issued. Bytes offered outside a burst are dropped.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                start      - burst request (honoured only in IDLE)
//                start_addr - first write address
//                length     - burst byte count (0 = empty, >DEPTH clamped)
//                wr_valid   - data byte offered
//                wr_data    - data byte
//                wr_ready   - byte accepted this cycle (WRITE state)
//                busy       - burst in progress (WRITE or DONE)
//                done       - one-cycle completion pulse
//                drop       - one-cycle pulse after a byte was offered
//                             outside WRITE and discarded
//                rd_addr    - read address
//                rd_data    - byte at rd_addr, zero latency
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_writer
  import ram_writer_pkg::*;
#(
  parameter int DEPTH = c_depth,
  parameter int AW    = c_aw
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       start_addr,
  input  logic [AW:0]         length,
  input  logic                wr_valid,
  input  logic [c_byte_w-1:0] wr_data,
  output logic                wr_ready,
  output logic                busy,
  output logic                done,
  output logic                drop,
  input  logic [AW-1:0]       rd_addr,
  output logic [c_byte_w-1:0] rd_data
);

  localparam logic [AW:0] c_depth_cnt = (AW+1)'(DEPTH);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [AW-1:0]  r_ptr;
  logic [AW:0]    r_remaining;
  logic           r_drop;

  logic [AW:0]    w_len_clamped;
  logic           w_accept;
  logic           w_hs;

  assign w_len_clamped = (length > c_depth_cnt) ? c_depth_cnt : length;
  assign w_accept      = (r_state == IDLE) && start && (length != '0);
  assign w_hs          = (r_state == WRITE) && wr_valid;

  // --------------------------------------------------------------------------
  // State register and burst bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // drop is registered so it never forms a path from wr_valid to an
      // output; it reports a discarded byte in the cycle after it was offered.
      r_drop  <= wr_valid && (r_state != WRITE);
      if (w_accept) begin
        r_ptr       <= start_addr;
        r_remaining <= w_len_clamped;
      end else if (w_hs) begin
        r_ptr       <= r_ptr + 1'b1;  // natural wrap at DEPTH = 2**AW
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and status outputs (status depends on registered state only)
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    wr_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    drop        = r_drop;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (length == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        if (w_hs && (r_remaining == (AW+1)'(1))) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  ram_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (w_hs),
    .waddr (r_ptr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule : ram_writer
`default_nettype wire

// File: tb/tb_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_writer
//  Description : Self-checking bench for ram_writer. A byte-array reference
//                model is updated from the burst rules (address wrap, length
//                clamp, drop outside a burst, reset clears everything) and
//                compared with the read port and status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] start_addr = '0;
  logic [8:0] length = '0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       busy;
  logic       done;
  logic       drop;
  logic [7:0] rd_addr = '0;
  logic [7:0] rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_mem [256];
  logic [7:0] dq [$];

  always #5 clk = ~clk;

  ram_writer #(
    .DEPTH (256),
    .AW    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .done       (done),
    .drop       (drop),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] expv);
    rd_addr = a;
    #1;
    check(tag, {24'd0, rd_data}, {24'd0, expv});
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 256; i++) begin
      rd_addr = i[7:0];
      #1;
      check(tag, {i[7:0], rd_data}, {i[7:0], exp_mem[i]});
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
  endtask

  // One burst. Called at posedge+1 with the DUT idle.
  // mode: 0 continuous valid, 1 valid toggling 1/0, 2 random valid.
  task automatic burst(input logic [7:0] a, input logic [8:0] len, input int mode,
                       input bit poke, input bit drop_in_done);
    int n;
    int cnt;
    int cyc;
    logic v;
    logic [7:0] d;
    logic [7:0] wa;
    n = (len > 9'd256) ? 256 : int'(len);
    start = 1'b1; start_addr = a; length = len; wr_valid = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, wr_ready}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    sync();
    start = 1'b0; start_addr = 8'($urandom); length = 9'($urandom);
    if (n == 0) begin
      wr_valid = drop_in_done; wr_data = 8'h77;
      @(negedge clk);
      check("empty_done", {31'd0, done}, 32'd1);
      check("empty_ready", {31'd0, wr_ready}, 32'd0);
      check("empty_busy", {31'd0, busy}, 32'd1);
      sync();
      wr_valid = 1'b0;
      @(negedge clk);
      check("empty_done_end", {31'd0, done}, 32'd0);
      check("empty_busy_end", {31'd0, busy}, 32'd0);
      check("done_drop", {31'd0, drop}, {31'd0, drop_in_done});
      sync();
      return;
    end
    cnt = 0;
    cyc = 0;
    wa  = a;
    while (cnt < n && cyc < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = (dq.size() != 0) ? dq.pop_front() : 8'($urandom);
      wa = a + cnt[7:0];
      wr_valid = v; wr_data = d; rd_addr = wa;
      start = poke && (cyc == 1);
      if (start) begin
        start_addr = 8'($urandom); length = 9'd7;
      end
      @(negedge clk);
      check("w_ready", {31'd0, wr_ready}, 32'd1);
      check("w_busy", {31'd0, busy}, 32'd1);
      check("w_done", {31'd0, done}, 32'd0);
      check("w_drop", {31'd0, drop}, 32'd0);
      check("rd_old", {24'd0, rd_data}, {24'd0, exp_mem[wa]});
      if (v) begin
        exp_mem[wa] = d;
        cnt++;
      end
      sync();
      cyc++;
    end
    wr_valid = 1'b0; start = 1'b0;
    check("burst_count", cnt, n);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_ready", {31'd0, wr_ready}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd1);
    check("rd_new", {24'd0, rd_data}, {24'd0, exp_mem[wa]});
    sync();
    @(negedge clk);
    check("post_done", {31'd0, done}, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);
    sync();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    // Reset: outputs go low asynchronously, storage cleared
    #2 rst = 1'b1;
    #1;
    check("rst_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_drop", {31'd0, drop}, 32'd0);
    sync();
    rst = 1'b0;
    check_mem("rst_mem");

    // Byte offered in IDLE is discarded and flagged for one cycle
    sync();
    wr_valid = 1'b1; wr_data = 8'h5A;
    @(negedge clk);
    check("drop_before", {31'd0, drop}, 32'd0);
    sync();
    wr_valid = 1'b0;
    @(negedge clk);
    check("drop_pulse", {31'd0, drop}, 32'd1);
    sync();
    @(negedge clk);
    check("drop_end", {31'd0, drop}, 32'd0);
    check_mem("drop_mem");

    // Basic 4-byte burst
    sync();
    dq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    burst(8'h10, 9'd4, 0, 1'b0, 1'b0);
    rd_check("b4_10", 8'h10, 8'hA1);
    rd_check("b4_11", 8'h11, 8'hB2);
    rd_check("b4_12", 8'h12, 8'hC3);
    rd_check("b4_13", 8'h13, 8'hD4);
    rd_check("b4_14", 8'h14, 8'h00);

    // Address wrap
    sync();
    dq = '{8'h11, 8'h22, 8'h33};
    burst(8'hFE, 9'd3, 0, 1'b0, 1'b0);
    rd_check("wrap_fe", 8'hFE, 8'h11);
    rd_check("wrap_ff", 8'hFF, 8'h22);
    rd_check("wrap_00", 8'h00, 8'h33);

    // Empty burst, with a byte offered during DONE
    sync();
    burst(8'h33, 9'd0, 0, 1'b0, 1'b1);
    check_mem("empty_mem");

    // Toggling valid, start pulsed mid-burst
    sync();
    burst(8'h80, 9'd5, 1, 1'b1, 1'b0);
    check_mem("toggle_mem");

    // Reset mid-burst after 2 of 6 bytes
    sync();
    start = 1'b1; start_addr = 8'h40; length = 9'd6;
    sync();
    start = 1'b0; wr_valid = 1'b1; wr_data = 8'h9A; rd_addr = 8'h40;
    sync();
    wr_data = 8'h9B;
    sync();
    wr_valid = 1'b0;
    check("pre_rst_byte", {24'd0, rd_data}, 32'h9A);
    rst = 1'b1;
    #1;
    clear_model();
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ready", {31'd0, wr_ready}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_mem40", {24'd0, rd_data}, 32'h00);
    sync();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("arst_no_done", {31'd0, done}, 32'd0);
      check("arst_idle", {31'd0, busy}, 32'd0);
    end
    check_mem("arst_mem");

    // First start right after reset release is taken on the next edge
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    burst(8'h41, 9'd2, 0, 1'b0, 1'b0);

    // Length clamp
    sync();
    burst(8'h20, 9'd300, 2, 1'b0, 1'b0);
    check_mem("clamp_mem");

    // Random bursts
    for (int r = 0; r < 10; r++) begin
      logic [8:0] rl;
      rl = (r % 4 == 3) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 24));
      sync();
      burst(8'($urandom), rl, 2, (r % 2 == 1), (r % 3 == 0));
      if (r % 3 == 2) check_mem("rand_mem");
    end
    check_mem("final_mem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ram_writer
`default_nettype wire
